// File: rtl/block_window_loader.sv
// block_window_loader
// Streams beat-map block records from an external synchronous ROM into a
// WINDOW-deep, time-ordered sliding window. Slot 0 always holds the nearest
// upcoming block; valid slots are contiguous from slot 0.
// ROM line 0 carries the block count N in its low bits; lines 1..N carry
// records {x, y, time, color, dir[2:0]}, MSB first.
// Optional feature macro: BLOCK_HIT_RETIRE_EN adds hit_in / hit_slot so the
// renderer can retire any valid slot early (time expiry of slot 0 wins).
module block_window_loader #(
    parameter int WINDOW      = 12,
    parameter int MAX_BLOCKS  = 256,
    parameter int COORD_W     = 12,
    parameter int TIME_W      = 18,
    parameter int ID_W        = 8,
    parameter int RAM_LATENCY = 2,
    localparam int AW = $clog2(MAX_BLOCKS + 1),
    localparam int RW = 2 * COORD_W + TIME_W + 4,
    localparam int CW = $clog2(WINDOW + 1),
    localparam int SW = $clog2(WINDOW)
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      restart_in,
    input  logic [TIME_W-1:0]         curr_time_in,
`ifdef BLOCK_HIT_RETIRE_EN
    input  logic                      hit_in,
    input  logic [SW-1:0]             hit_slot,
`endif
    output logic [AW-1:0]             rom_addr,
    input  logic [RW-1:0]             rom_data,
    output logic [WINDOW*COORD_W-1:0] block_x,
    output logic [WINDOW*COORD_W-1:0] block_y,
    output logic [WINDOW*TIME_W-1:0]  block_time,
    output logic [WINDOW-1:0]         block_color,
    output logic [WINDOW*3-1:0]       block_direction,
    output logic [WINDOW*ID_W-1:0]    block_ID,
    output logic [WINDOW-1:0]         block_valid,
    output logic [CW-1:0]             window_count,
    output logic                      song_done,
    output logic                      loader_busy,
    output logic [TIME_W-1:0]         curr_time_out
);

    // Line counters need one bit more than the address so next_line can
    // point one past the last record without wrapping.
    localparam int LW    = AW + 1;
    localparam int LAT_W = $clog2(RAM_LATENCY + 1);

    typedef enum logic [2:0] {
        S_HEADER,
        S_FILL,
        S_TRACK,
        S_FETCH,
        S_SHIFT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [RW-1:0]   rec;
        logic [ID_W-1:0] id;
    } slot_t;

    state_t            state_q, state_d;
    slot_t             slot_q [WINDOW];
    slot_t             slot_d [WINDOW];
    logic [WINDOW-1:0] valid_q, valid_d;
    logic [CW-1:0]     count_q, count_d;
    logic              done_q, done_d;
    logic [LW-1:0]     n_q, n_d;
    logic [LW-1:0]     next_line_q, next_line_d;
    logic [AW-1:0]     rom_addr_q, rom_addr_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [CW-1:0]     fill_q, fill_d;
    slot_t             inc_q, inc_d;
    logic              inc_valid_q, inc_valid_d;
    logic [SW-1:0]     base_q, base_d;
    logic [TIME_W-1:0] tdly_q;

    logic              lat_hit;
    logic [LW-1:0]     hdr_cnt;
    logic              expire;
    logic              hit_ok;
    logic [SW-1:0]     hit_base;
    logic              retire;
    logic              more_lines;
    logic              go_fetch;

    // ID is the ROM line index, truncated (or zero-extended) to ID_W bits.
    function automatic logic [ID_W-1:0] line_id(input logic [LW-1:0] line);
        logic [LW+ID_W-1:0] ext;
        ext = {{ID_W{1'b0}}, line};
        return ext[ID_W-1:0];
    endfunction

    assign lat_hit    = (lat_q == LAT_W'(RAM_LATENCY));
    assign hdr_cnt    = {1'b0, rom_data[AW-1:0]};
    assign more_lines = (next_line_q <= n_q);

    // Retirement arbitration in TRACK: restart > slot-0 expiry > hit.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path can leave it unassigned and infer a latch.
        expire   = 1'b0;
        hit_ok   = 1'b0;
        hit_base = '0;
        if (state_q == S_TRACK && !restart_in) begin
            expire = valid_q[0] && (curr_time_in > slot_q[0].rec[TIME_W+3:4]);
`ifdef BLOCK_HIT_RETIRE_EN
            if (!expire && hit_in) begin
                for (int i = 0; i < WINDOW; i++) begin
                    if (hit_slot == SW'(i) && valid_q[i]) begin
                        hit_ok   = 1'b1;
                        hit_base = SW'(i);
                    end
                end
            end
`endif
        end
        retire   = expire || hit_ok;
        go_fetch = retire && more_lines;
    end

    // The refill read is issued in the deciding TRACK cycle itself, so a
    // retirement round costs TRACK + RAM_LATENCY + SHIFT cycles.
    assign rom_addr = go_fetch ? next_line_q[AW-1:0] : rom_addr_q;

    // Next-state logic: loader FSM, window update and restart override.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        valid_d     = valid_q;
        done_d      = done_q;
        n_d         = n_q;
        next_line_d = next_line_q;
        rom_addr_d  = rom_addr_q;
        lat_d       = lat_q;
        fill_d      = fill_q;
        inc_d       = inc_q;
        inc_valid_d = inc_valid_q;
        base_d      = base_q;

        case (state_q)
            S_HEADER: begin
                if (lat_hit) begin
                    n_d         = (hdr_cnt > LW'(MAX_BLOCKS)) ? LW'(MAX_BLOCKS) : hdr_cnt;
                    next_line_d = LW'(1);
                    lat_d       = '0;
                    fill_d      = '0;
                    if (n_d == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        rom_addr_d = AW'(1);
                        state_d    = S_FILL;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end

            S_FILL: begin
                if (lat_hit) begin
                    for (int i = 0; i < WINDOW; i++) begin
                        if (fill_q == CW'(i)) begin
                            slot_d[i].rec = rom_data;
                            slot_d[i].id  = line_id(next_line_q);
                            valid_d[i]    = 1'b1;
                        end
                    end
                    next_line_d = next_line_q + 1'b1;
                    lat_d       = '0;
                    if (fill_q == CW'(WINDOW - 1) || next_line_q == n_q) begin
                        state_d = S_TRACK;
                    end else begin
                        rom_addr_d = next_line_d[AW-1:0];
                        fill_d     = fill_q + 1'b1;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end

            S_TRACK: begin
                if (retire) begin
                    base_d = expire ? '0 : hit_base;
                    if (more_lines) begin
                        rom_addr_d = next_line_q[AW-1:0];
                        lat_d      = LAT_W'(1);
                        state_d    = S_FETCH;
                    end else begin
                        inc_d       = '0;
                        inc_valid_d = 1'b0;
                        state_d     = S_SHIFT;
                    end
                end else if (!valid_q[0] && !more_lines) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end

            S_FETCH: begin
                if (lat_hit) begin
                    inc_d.rec   = rom_data;
                    inc_d.id    = line_id(next_line_q);
                    inc_valid_d = 1'b1;
                    next_line_d = next_line_q + 1'b1;
                    lat_d       = '0;
                    state_d     = S_SHIFT;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end

            S_SHIFT: begin
                for (int i = 0; i < WINDOW - 1; i++) begin
                    if (SW'(i) >= base_q) begin
                        slot_d[i]  = slot_q[i+1];
                        valid_d[i] = valid_q[i+1];
                    end
                end
                slot_d[WINDOW-1]  = inc_q;
                valid_d[WINDOW-1] = inc_valid_q;
                state_d           = S_TRACK;
            end

            S_DONE: begin
                state_d = S_DONE;
            end

            default: begin
                state_d = S_HEADER;
            end
        endcase

        // Restart wins over everything; an outstanding fetch is simply
        // abandoned because HEADER re-times its own read from scratch.
        if (restart_in) begin
            state_d     = S_HEADER;
            valid_d     = '0;
            done_d      = 1'b0;
            n_d         = '0;
            next_line_d = '0;
            rom_addr_d  = '0;
            lat_d       = '0;
            fill_d      = '0;
            inc_valid_d = 1'b0;
            base_d      = '0;
        end

        count_d = '0;
        for (int i = 0; i < WINDOW; i++) begin
            count_d = count_d + CW'(valid_d[i]);
        end
    end

    // State and window registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= S_HEADER;
            // NOTE: the slots are a flop bank read in parallel by the renderer,
            // so they reset with everything else; a RAM would not be reset.
            for (int i = 0; i < WINDOW; i++) begin
                slot_q[i] <= '0;
            end
            valid_q     <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            n_q         <= '0;
            next_line_q <= '0;
            rom_addr_q  <= '0;
            lat_q       <= '0;
            fill_q      <= '0;
            inc_q       <= '0;
            inc_valid_q <= 1'b0;
            base_q      <= '0;
            tdly_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments for all state so every register
            // samples the pre-edge values; blocking stays in always_comb.
            state_q     <= state_d;
            slot_q      <= slot_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            done_q      <= done_d;
            n_q         <= n_d;
            next_line_q <= next_line_d;
            rom_addr_q  <= rom_addr_d;
            lat_q       <= lat_d;
            fill_q      <= fill_d;
            inc_q       <= inc_d;
            inc_valid_q <= inc_valid_d;
            base_q      <= base_d;
            tdly_q      <= curr_time_in;
        end
    end

    // Unpack the slot registers onto the flat per-slot output buses.
    always_comb begin
        block_x         = '0;
        block_y         = '0;
        block_time      = '0;
        block_color     = '0;
        block_direction = '0;
        block_ID        = '0;
        for (int i = 0; i < WINDOW; i++) begin
            block_x[i*COORD_W +: COORD_W]  = slot_q[i].rec[RW-1 -: COORD_W];
            block_y[i*COORD_W +: COORD_W]  = slot_q[i].rec[RW-1-COORD_W -: COORD_W];
            block_time[i*TIME_W +: TIME_W] = slot_q[i].rec[TIME_W+3:4];
            block_color[i]                 = slot_q[i].rec[3];
            block_direction[i*3 +: 3]      = slot_q[i].rec[2:0];
            block_ID[i*ID_W +: ID_W]       = slot_q[i].id;
        end
    end

    assign block_valid   = valid_q;
    assign window_count  = count_q;
    assign song_done     = done_q;
    assign loader_busy   = (state_q != S_TRACK);
    assign curr_time_out = tdly_q;

endmodule

// File: doc/block_window_loader.md
Name: block_window_loader

Overview:
- Parametrised successor of the fixed 12-slot block loader.
- Streams beat-map block records from an external synchronous ROM into a WINDOW-deep, time-ordered sliding window; slot 0 is always the nearest upcoming block.
- Adds a header-driven song length, per-slot valid bits, end-of-song handling, restart, and configurable ROM latency.
- Sits between the song-time counter and the renderer/collision logic.

Parameters:
- WINDOW, 12, number of window slots (≥2).
- MAX_BLOCKS, 256, maximum records per song.
- COORD_W, 12, x/y width.
- TIME_W, 18, timestamp width.
- ID_W, 8, block ID width.
- RAM_LATENCY, 2, cycles from rom_addr to valid rom_data (≥1).

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  asynchronous active-high reset.
- restart_in  in  1  one-cycle pulse: reload the song from the header.
- curr_time_in  in  TIME_W  current song time.
- rom_addr  out  AW=$clog2(MAX_BLOCKS+1)  ROM line address.
- rom_data  in  2*COORD_W+TIME_W+4  record {x, y, time, color, dir[2:0]}, MSB first; line 0 low bits = block count N.
- block_x / block_y  out  WINDOW×COORD_W  slot coordinates.
- block_time  out  WINDOW×TIME_W  slot timestamps.
- block_color  out  WINDOW  0 = blue, 1 = red.
- block_direction  out  WINDOW×3  0 = up, 1 = right, 2 = down, 3 = left, 4 = any.
- block_ID  out  WINDOW×ID_W  ROM line index of the slot, truncated.
- block_valid  out  WINDOW  slot holds a live block.
- window_count  out  $clog2(WINDOW+1)  popcount of block_valid.
- song_done  out  1  all records consumed and window empty.
- loader_busy  out  1  high in every state except TRACK.
- curr_time_out  out  TIME_W  curr_time_in delayed one cycle, aligned with the window.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All outputs, rom_addr and counters = 0.
  - block_valid = 0, song_done = 0.
  - State = HEADER.
- Registered ROM fetch: a read issued with rom_addr = A in cycle t is captured at t+RAM_LATENCY. One latency counter is shared by all fetches. Only one read is outstanding at a time.
- HEADER:
  - Drive rom_addr = 0 and wait RAM_LATENCY cycles.
  - Latch N = min(rom_data count, MAX_BLOCKS).
  - Set next_line = 1.
  - If N = 0, go to DONE; otherwise go to FILL.
- FILL:
  - For k = 0..min(N,WINDOW)−1: fetch line k+1, write slot k, set valid[k], set ID = k+1.
  - Fill is sequential, RAM_LATENCY+1 cycles per slot max; back-to-back pipelining is permitted if equivalent.
  - next_line advances per fetch. Then go to TRACK.
- TRACK, checked each cycle:
  - If valid[0] and curr_time_in > block_time[0] (strictly greater, unsigned), retire slot 0.
  - If next_line ≤ N: drive rom_addr = next_line, go to FETCH.
  - Otherwise go to SHIFT with the incoming slot marked empty.
- FETCH: wait RAM_LATENCY cycles, then go to SHIFT with the incoming slot = rom_data and ID = next_line; next_line += 1.
- SHIFT (one cycle):
  - Slots i ← i+1 for i < WINDOW−1.
  - Slot WINDOW−1 ← incoming record (valid = 1) or zeros (valid = 0).
  - Return to TRACK.
- Retirement rate: at most one retirement per TRACK→…→TRACK round trip. Multiple expired blocks drain on consecutive rounds.
- DONE:
  - Entered from TRACK when valid[0] = 0 and next_line > N.
  - song_done = 1 and holds; all slots are invalid.
- restart_in, accepted in any state: clear all valid bits and song_done, go to HEADER next cycle. Any outstanding fetch is discarded. restart_in has priority over retirement and hit.
- Window ordering invariant: valid slots are contiguous from slot 0, with no holes.
- Timestamp ordering: ROM timestamps are non-decreasing by contract. The block does not sort.
- window_count and song_done are registered and update in the same cycle as block_valid.

Optional Feature:
- Macro: BLOCK_HIT_RETIRE_EN.
- When defined, adds ports hit_in (1) and hit_slot ($clog2(WINDOW)).
- In TRACK, hit_in with valid[hit_slot] retires that slot early:
  - Slots above hit_slot shift down one.
  - A refill into slot WINDOW−1 follows the normal FETCH/SHIFT path.
- Priority: restart_in > time expiry of slot 0 > hit_in. A hit losing arbitration, or arriving outside TRACK or on an invalid slot, is dropped.
- When the macro is undefined, the ports are absent and only time expiry retires blocks.

Test Plan:
- Header N = 20, RAM_LATENCY = 2, curr_time = 0 → after fill: block_valid = 12'hFFF, IDs 1..12, loader_busy = 0, rom_addr stopped at 12.
- Set curr_time_in = block_time[0]+1 with only slot 0 expired → exactly one SHIFT: slot 0 gets old slot 1, slot 11 = line 13, ID 13.
- Header N = 5 → valid = 12'h01F, window_count = 5. Advance time past all 5 → song_done = 1, window_count = 0, no rom_addr beyond 5.
- Jump curr_time_in past 3 timestamps → three consecutive retirements, 3×(RAM_LATENCY+2) cycles, ordering preserved.
- restart_in pulsed mid-FETCH → valid = 0 next cycle, HEADER refetch, window identical to the first load.
- (BLOCK_HIT_RETIRE_EN) hit_slot = 4 in TRACK → old slots 5..11 move to 4..10, slot 11 refilled from next_line. A simultaneous slot-0 expiry wins and the hit is dropped.
